// File: rtl/clock_12h_core.sv
// -----------------------------------------------------------------------------
// clock_12h_core
// Timekeeping stage for a 12-hour clock display. A prescaler divides the board
// clock into a seconds advance; time is kept as BCD hh:mm:ss plus an AM/PM
// flag. A time-set mode suspends counting and accepts hour/minute increment
// pulses.
//
// Ports:
//   clk       board clock, all state changes on its rising edge
//   rst       asynchronous, active-high reset (time 12:00:00 AM)
//   en        run enable; 0 freezes prescaler and time
//   speed     0 = DIV_SLOW clocks per second, 1 = DIV_FAST
//   set_mode  1 = time-set mode, counting suspended
//   inc_hr    one-clk pulse, hour +1 while in set mode
//   inc_min   one-clk pulse, minute +1 (no carry) while in set mode
//   hr_tens / hr_ones / min_tens / min_ones / sec_tens / sec_ones
//             BCD display digits, straight from state registers
//   pm        0 = AM, 1 = PM
//   sec_tick  one-clk strobe on every seconds advance
// -----------------------------------------------------------------------------
module clock_12h_core #(
  parameter int unsigned DIV_SLOW = 100000000,
  parameter int unsigned DIV_FAST = 1000000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       speed,
  input  logic       set_mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic       hr_tens,
  output logic [3:0] hr_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic       sec_tick
);

  // Two-digit BCD value in the range 00..59 (minutes, seconds).
  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] ones;
  } bcd60_t;

  // Hour in the range 01..12 together with the AM/PM flag, since the flag
  // only ever changes as a side effect of the hour stepping 11 -> 12.
  typedef struct packed {
    logic       tens;
    logic [3:0] ones;
    logic       pm;
  } hour_t;

  localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(DIV_FAST - 1);
  localparam hour_t  HOUR_RST = '{tens: 1'b1, ones: 4'd2, pm: 1'b0};
  localparam bcd60_t ZERO60   = '{tens: 3'd0, ones: 4'd0};

  // ---------------------------------------------------------------------------
  // Digit arithmetic
  // ---------------------------------------------------------------------------
  function automatic bcd60_t inc60(input bcd60_t v);
    bcd60_t r;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = (v.tens == 3'd5) ? 3'd0 : v.tens + 3'd1;
    end else begin
      r.ones = v.ones + 4'd1;
      r.tens = v.tens;
    end
    return r;
  endfunction

  function automatic logic is_59(input bcd60_t v);
    return (v.tens == 3'd5) && (v.ones == 4'd9);
  endfunction

  // 12 -> 01 -> ... -> 09 -> 10 -> 11 -> 12; pm flips only on 11 -> 12.
  function automatic hour_t inc_hour(input hour_t h);
    hour_t r;
    r = h;
    if (h.tens && h.ones == 4'd2) begin
      r.tens = 1'b0;
      r.ones = 4'd1;
    end else if (!h.tens && h.ones == 4'd9) begin
      r.tens = 1'b1;
      r.ones = 4'd0;
    end else begin
      r.ones = h.ones + 4'd1;
      if (h.tens && h.ones == 4'd1) r.pm = ~h.pm;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pcnt_q, pcnt_n;
  hour_t            hour_q, hour_n;
  bcd60_t           min_q,  min_n;
  bcd60_t           sec_q,  sec_n;
  logic             tick_q, tick_n;
  logic             set_q;            // set_mode seen on the previous edge
  logic [CNT_W-1:0] last;

  assign last = speed ? LAST_FAST : LAST_SLOW;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    pcnt_n = pcnt_q;
    hour_n = hour_q;
    min_n  = min_q;
    sec_n  = sec_q;
    tick_n = 1'b0;

    if (set_mode) begin
      // Prescaler parked at 0 so leaving set mode gives a full period before
      // the first advance. Increments are honoured regardless of en.
      pcnt_n = '0;
      if (!set_q)  sec_n  = ZERO60;
      if (inc_min) min_n  = inc60(min_q);
      if (inc_hr)  hour_n = inc_hour(hour_q);
    end else if (en) begin
      // >= rather than == so a switch to fast speed with the count already
      // beyond the fast limit still fires on the next cycle.
      if (pcnt_q >= last) begin
        pcnt_n = '0;
        tick_n = 1'b1;
        sec_n  = inc60(sec_q);
        if (is_59(sec_q)) begin
          min_n = inc60(min_q);
          if (is_59(min_q)) hour_n = inc_hour(hour_q);
        end
      end else begin
        pcnt_n = pcnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      hour_q <= HOUR_RST;
      min_q  <= ZERO60;
      sec_q  <= ZERO60;
      tick_q <= 1'b0;
      set_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      pcnt_q <= pcnt_n;
      hour_q <= hour_n;
      min_q  <= min_n;
      sec_q  <= sec_n;
      tick_q <= tick_n;
      set_q  <= set_mode;
    end
  end

  assign hr_tens  = hour_q.tens;
  assign hr_ones  = hour_q.ones;
  assign pm       = hour_q.pm;
  assign min_tens = min_q.tens;
  assign min_ones = min_q.ones;
  assign sec_tens = sec_q.tens;
  assign sec_ones = sec_q.ones;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_clock_12h_core.sv
// -----------------------------------------------------------------------------
// tb_clock_12h_core
// Directed bench for clock_12h_core with DIV_SLOW=4, DIV_FAST=2. A reference
// model keeps time as seconds since midnight on a 24-hour day and derives the
// 12-hour display from it; it is compared with the DUT on every falling edge.
// Literal hand-computed expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_clock_12h_core;

  logic       clk = 1'b0;
  logic       rst, en, speed, set_mode, inc_hr, inc_min;
  logic       hr_tens;
  logic [3:0] hr_ones;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       pm;
  logic       sec_tick;

  clock_12h_core #(
    .DIV_SLOW(4),
    .DIV_FAST(2),
    .CNT_W   (27)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .speed   (speed),
    .set_mode(set_mode),
    .inc_hr  (inc_hr),
    .inc_min (inc_min),
    .hr_tens (hr_tens),
    .hr_ones (hr_ones),
    .min_tens(min_tens),
    .min_ones(min_ones),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .pm      (pm),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  logic [20:0] dut_vec;
  assign dut_vec = {hr_tens, hr_ones, min_tens, min_ones,
                    sec_tens, sec_ones, pm, sec_tick};

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_t;          // seconds since midnight, 0..86399
  int m_pcnt;
  int m_tick;
  int m_prev_set;

  function automatic logic [20:0] pack(int h12, int m, int s, int p, int t);
    return {1'(h12 / 10), 4'(h12 % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), 1'(p), 1'(t)};
  endfunction

  function automatic logic [20:0] model_vec();
    int h24, h12;
    h24 = m_t / 3600;
    h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
    return pack(h12, (m_t / 60) % 60, m_t % 60, (h24 >= 12) ? 1 : 0, m_tick);
  endfunction

  task automatic model_reset();
    m_t        = 0;
    m_pcnt     = 0;
    m_tick     = 0;
    m_prev_set = 0;
  endtask

  task automatic model_step();
    int div, h, m, s;
    div    = speed ? 2 : 4;
    h      = m_t / 3600;
    m      = (m_t / 60) % 60;
    s      = m_t % 60;
    m_tick = 0;
    if (set_mode) begin
      m_pcnt = 0;
      if (m_prev_set == 0) s = 0;
      if (inc_min) m = (m + 1) % 60;
      if (inc_hr)  h = (h + 1) % 24;
      m_t = h * 3600 + m * 60 + s;
    end else if (en) begin
      if (m_pcnt >= div - 1) begin
        m_pcnt = 0;
        m_tick = 1;
        m_t    = (m_t + 1) % 86400;
      end else begin
        m_pcnt++;
      end
    end
    m_prev_set = set_mode ? 1 : 0;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Time digits and pm only (sec_tick excluded).
  task automatic check_time(string name, int h12, int m, int s, int p);
    check(name, 32'(dut_vec >> 1), 32'(pack(h12, m, s, p, 0) >> 1));
  endtask

  // One clock: the model consumes the inputs the DUT sampled at this edge;
  // returns 1 time unit after the edge.
  task automatic cycle(int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
    end
  endtask

  // Cycles until sec_tick is seen, bounded at 50.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (sec_tick !== 1'b1 && n < 50);
  endtask

  task automatic pulse(input logic hr, input logic mn);
    inc_hr  = hr;
    inc_min = mn;
    cycle();
    inc_hr  = 1'b0;
    inc_min = 1'b0;
    cycle();
  endtask

  // Enter set mode (seconds clear), apply increments, leave set mode.
  task automatic set_clock(int hrs, int mins);
    set_mode = 1'b1;
    cycle();
    for (int i = 0; i < hrs; i++)  pulse(1'b1, 1'b0);
    for (int i = 0; i < mins; i++) pulse(1'b0, 1'b1);
    set_mode = 1'b0;
  endtask

  // Continuous per-cycle comparison against the model.
  always @(negedge clk) check("cycle", 32'(dut_vec), 32'(model_vec()));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks;
    rst = 1'b1; en = 1'b0; speed = 1'b0;
    set_mode = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
    model_reset();
    cycle(2);
    check_time("reset_state", 12, 0, 0, 0);
    check("reset_tick", 32'(sec_tick), 0);

    // 1. Reset mid-count, then run at slow speed.
    rst = 1'b0; en = 1'b1;
    cycle(6);
    #2 rst = 1'b1;
    model_reset();
    #1 check_time("async_reset", 12, 0, 0, 0);
    cycle(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      check("slow_period", n, 4);
    end
    check_time("after_4_ticks", 12, 0, 4, 0);

    // 2. Rollover chains (fast speed for the bulk counting).
    speed = 1'b1;
    set_clock(11, 59);
    check_time("set_1159am", 11, 59, 0, 0);
    cycle(58 * 2);
    check_time("at_115958am", 11, 59, 58, 0);
    wait_tick(n);
    check_time("at_115959am", 11, 59, 59, 0);
    wait_tick(n);
    check_time("noon_pm", 12, 0, 0, 1);
    set_clock(11, 59);
    cycle(58 * 2);
    check_time("at_115958pm", 11, 59, 58, 1);
    wait_tick(n);
    wait_tick(n);
    check_time("midnight_am", 12, 0, 0, 0);
    set_clock(0, 59);
    cycle(59 * 2);
    check_time("at_125959", 12, 59, 59, 0);
    wait_tick(n);
    check_time("one_am", 1, 0, 0, 0);

    // 3. Set mode.
    set_clock(2, 27);
    cycle(41 * 2);
    check_time("at_032741", 3, 27, 41, 0);
    speed    = 1'b0;
    set_mode = 1'b1;
    cycle();
    check_time("set_clears_sec", 3, 27, 0, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (sec_tick === 1'b1) ticks++;
    end
    check("set_no_ticks", ticks, 0);
    for (int i = 0; i < 13; i++) pulse(1'b1, 1'b0);
    check_time("hr_wrap_13", 4, 27, 0, 1);
    for (int i = 0; i < 34; i++) pulse(1'b0, 1'b1);
    check_time("min_wrap_34", 4, 1, 0, 1);
    pulse(1'b1, 1'b1);
    check_time("both_inc", 5, 2, 0, 1);
    set_mode = 1'b0;
    pulse(1'b1, 1'b1);
    check_time("inc_ignored", 5, 2, 0, 1);

    // 4. Speed switch with the count past the fast limit.
    wait_tick(n);
    cycle(2);
    speed = 1'b1;
    cycle();
    check("switch_tick", 32'(sec_tick), 1);
    for (int i = 0; i < 2; i++) begin
      wait_tick(n);
      check("fast_period", n, 2);
    end
    check_time("after_fast", 5, 2, 4, 1);

    // 5. Enable hold mid-count.
    speed = 1'b0;
    wait_tick(n);
    cycle();
    en    = 1'b0;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (sec_tick === 1'b1) ticks++;
    end
    check("hold_no_ticks", ticks, 0);
    check_time("hold_frozen", 5, 2, 5, 1);
    en = 1'b1;
    wait_tick(n);
    check("hold_resume", n, 3);
    check_time("after_hold", 5, 2, 6, 1);

    // 6. Reset during set mode with inc_hr held.
    set_mode = 1'b1;
    inc_hr   = 1'b1;
    cycle();
    #2 rst = 1'b1;
    model_reset();
    #1 check_time("reset_in_set", 12, 0, 0, 0);
    cycle(2);
    rst = 1'b0; set_mode = 1'b0; inc_hr = 1'b0;
    wait_tick(n);
    check("post_reset_period", n, 4);
    check_time("post_reset_run", 12, 0, 1, 0);

    cycle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
